// File: rtl/cache_fill_arbiter_pkg.sv
// Shared types and sizing helpers for the cache fill arbiter and its arbiter sub-block.
package cache_fill_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_WRITE = 2'd3
    } state_t;

    // Width of a word offset inside a block.
    function automatic int off_w(input int block_words);
        return $clog2(block_words);
    endfunction

    // Width of a channel index; a single channel still needs one bit.
    function automatic int idx_w(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

endpackage

// File: rtl/cache_fill_arbiter_rr.sv
// Request arbiter: fixed lowest-index priority, or round-robin starting at ptr.
module rr_arbiter
    import cache_fill_arbiter_pkg::*;
#(
    parameter  int NUM_CH = 2,
    localparam int IDX_W  = idx_w(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [IDX_W-1:0]  ptr,
    input  logic              rr_mode,
    output logic [NUM_CH-1:0] grant,
    output logic [IDX_W-1:0]  grant_idx,
    output logic              grant_valid
);

    int               start_s;
    logic [IDX_W-1:0] cand_s;

    // Scan channels from the start point, wrapping, and take the first requester.
    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        start_s     = rr_mode ? int'(ptr) : 0;
        cand_s      = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            cand_s = IDX_W'((start_s + k) % NUM_CH);
            if (!grant_valid && req[cand_s]) begin
                grant[cand_s] = 1'b1;
                grant_idx     = cand_s;
                grant_valid   = 1'b1;
            end else begin
            end
        end
    end

endmodule

// File: rtl/cache_fill_arbiter.sv
// Arbitrates channel block fills and single-word writes onto one pipelined memory port.
module cache_fill_arbiter
    import cache_fill_arbiter_pkg::*;
#(
    parameter  int NUM_CH      = 2,
    parameter  int ADDR_W      = 16,
    parameter  int DATA_W      = 16,
    parameter  int BLOCK_WORDS = 8,
    parameter  int MEM_LAT     = 4,
    parameter  int PRIO_MODE   = 0,
    localparam int OFF_W       = off_w(BLOCK_WORDS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH-1:0]        ch_req,
    input  logic [NUM_CH-1:0]        ch_we,
    input  logic [NUM_CH*ADDR_W-1:0] ch_addr,
    input  logic [NUM_CH*DATA_W-1:0] ch_wdata,
    output logic [NUM_CH-1:0]        ch_stall,
    output logic [NUM_CH-1:0]        ch_done,
    output logic [NUM_CH-1:0]        fill_valid,
    output logic [DATA_W-1:0]        fill_data,
    output logic [OFF_W-1:0]         fill_offset,
    output logic                     mem_en,
    output logic                     mem_wr,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [DATA_W-1:0]        mem_wdata,
    input  logic [DATA_W-1:0]        mem_rdata,
    input  logic                     mem_rvalid
);

    localparam int               IDX_W    = idx_w(NUM_CH);
    localparam logic [OFF_W-1:0] LAST_OFF = OFF_W'(BLOCK_WORDS - 1);

    if (MEM_LAT < 1) begin : g_lat_chk
        $error("MEM_LAT must be at least 1");
    end else begin : g_lat_ok
    end

    state_t             state_r, state_nxt_s;
    logic [IDX_W-1:0]   gidx_r, gidx_nxt_s;
    logic [ADDR_W-1:0]  addr_r, addr_nxt_s;
    logic [DATA_W-1:0]  wdata_r, wdata_nxt_s;
    logic [OFF_W-1:0]   issue_cnt_r, issue_cnt_nxt_s;
    logic [OFF_W-1:0]   recv_cnt_r, recv_cnt_nxt_s;
    logic [IDX_W-1:0]   ptr_r, ptr_nxt_s;

    logic [NUM_CH-1:0]  arb_grant_s;
    logic [IDX_W-1:0]   arb_idx_s;
    logic               arb_valid_s;
    logic               rx_s;
    logic               last_rx_s;

    rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
        .req         (ch_req),
        .ptr         (ptr_r),
        .rr_mode     (PRIO_MODE == 1),
        .grant       (arb_grant_s),
        .grant_idx   (arb_idx_s),
        .grant_valid (arb_valid_s)
    );

    // Returns only count while a fill is outstanding; anything else is a stray.
    assign rx_s      = mem_rvalid && ((state_r == ST_ISSUE) || (state_r == ST_DRAIN));
    assign last_rx_s = rx_s && (recv_cnt_r == LAST_OFF);

    // Next-state, grant capture and counter advance.
    always_comb begin
        state_nxt_s     = state_r;
        gidx_nxt_s      = gidx_r;
        addr_nxt_s      = addr_r;
        wdata_nxt_s     = wdata_r;
        issue_cnt_nxt_s = issue_cnt_r;
        recv_cnt_nxt_s  = recv_cnt_r;
        ptr_nxt_s       = ptr_r;
        if (rx_s) begin
            recv_cnt_nxt_s = recv_cnt_r + OFF_W'(1);
        end else begin
            recv_cnt_nxt_s = recv_cnt_r;
        end
        case (state_r)
            ST_IDLE: begin
                if (arb_valid_s) begin
                    gidx_nxt_s  = arb_idx_s;
                    addr_nxt_s  = ch_addr[arb_idx_s*ADDR_W +: ADDR_W];
                    wdata_nxt_s = ch_wdata[arb_idx_s*DATA_W +: DATA_W];
                    state_nxt_s = (|(arb_grant_s & ch_we)) ? ST_WRITE : ST_ISSUE;
                    ptr_nxt_s   = (arb_idx_s == IDX_W'(NUM_CH - 1)) ? '0 : arb_idx_s + IDX_W'(1);
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                issue_cnt_nxt_s = issue_cnt_r + OFF_W'(1);
                if (issue_cnt_r == LAST_OFF) begin
                    state_nxt_s     = ST_DRAIN;
                    issue_cnt_nxt_s = '0;
                end else begin
                    state_nxt_s = ST_ISSUE;
                end
            end
            ST_DRAIN: begin
                if (last_rx_s) begin
                    state_nxt_s    = ST_IDLE;
                    recv_cnt_nxt_s = '0;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            ST_WRITE: state_nxt_s = ST_IDLE;
            default:  state_nxt_s = ST_IDLE;
        endcase
    end

    // Memory strobes, fill delivery and completion pulses.
    always_comb begin
        ch_done     = '0;
        fill_valid  = '0;
        fill_data   = '0;
        fill_offset = '0;
        mem_en      = 1'b0;
        mem_wr      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        case (state_r)
            ST_WRITE: begin
                mem_en          = 1'b1;
                mem_wr          = 1'b1;
                mem_addr        = addr_r;
                mem_wdata       = wdata_r;
                ch_done[gidx_r] = 1'b1;
            end
            ST_ISSUE: begin
                mem_en   = 1'b1;
                mem_addr = {addr_r[ADDR_W-1:OFF_W], issue_cnt_r};
            end
            default: mem_en = 1'b0;
        endcase
        if (rx_s) begin
            fill_valid[gidx_r] = 1'b1;
            fill_data          = mem_rdata;
            fill_offset        = recv_cnt_r;
        end else begin
            fill_data = '0;
        end
        if (last_rx_s) begin
            ch_done[gidx_r] = 1'b1;
        end else begin
            fill_offset = fill_offset;
        end
        ch_stall = ch_req & ~ch_done;
    end

    // State and transaction registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            gidx_r      <= '0;
            addr_r      <= '0;
            wdata_r     <= '0;
            issue_cnt_r <= '0;
            recv_cnt_r  <= '0;
            ptr_r       <= '0;
        end else begin
            state_r     <= state_nxt_s;
            gidx_r      <= gidx_nxt_s;
            addr_r      <= addr_nxt_s;
            wdata_r     <= wdata_nxt_s;
            issue_cnt_r <= issue_cnt_nxt_s;
            recv_cnt_r  <= recv_cnt_nxt_s;
            ptr_r       <= ptr_nxt_s;
        end
    end

endmodule

// File: tb/tb_cache_fill_arbiter.sv
// Bench for cache_fill_arbiter: two builds driven by directed and random requests, checked cycle by cycle against a transaction timeline model.
module tb_cache_fill_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    for (genvar e = 0; e < 2; e++) begin : g_env
        localparam int NC  = (e == 0) ? 2 : 3;
        localparam int BW  = (e == 0) ? 8 : 4;
        localparam int LAT = (e == 0) ? 4 : 1;
        localparam int PM  = (e == 0) ? 0 : 1;
        localparam int OW  = $clog2(BW);
        localparam int AW  = 16;
        localparam int DW  = 16;
        localparam int DIR_CH = (e == 0) ? 0 : NC - 1;
        localparam logic [15:0] DIR_ADDR = (e == 0) ? 16'h0013 : 16'hFFFF;
        localparam int RAND_P = (e == 0) ? 35 : 100;

        logic             rst;
        logic [NC-1:0]    ch_req, ch_we, ch_stall, ch_done, fill_valid;
        logic [NC*AW-1:0] ch_addr;
        logic [NC*DW-1:0] ch_wdata;
        logic [DW-1:0]    fill_data, mem_wdata, mem_rdata;
        logic [OW-1:0]    fill_offset;
        logic             mem_en, mem_wr, mem_rvalid;
        logic [AW-1:0]    mem_addr;

        cache_fill_arbiter #(
            .NUM_CH(NC), .ADDR_W(AW), .DATA_W(DW),
            .BLOCK_WORDS(BW), .MEM_LAT(LAT), .PRIO_MODE(PM)
        ) u_dut (
            .clk(clk), .rst(rst),
            .ch_req(ch_req), .ch_we(ch_we), .ch_addr(ch_addr), .ch_wdata(ch_wdata),
            .ch_stall(ch_stall), .ch_done(ch_done),
            .fill_valid(fill_valid), .fill_data(fill_data), .fill_offset(fill_offset),
            .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
            .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid)
        );

        // requester intent, applied just after each rising edge
        logic        s_rst;
        logic        s_req [NC];
        logic        s_we  [NC];
        logic [15:0] s_addr  [NC];
        logic [15:0] s_wdata [NC];

        // memory: contents plus in-flight read returns
        logic [15:0] mem_arr [int];
        int          due_q [$];
        logic [15:0] dat_q [$];

        // timeline model: what must appear in each future cycle
        int          cyc, free_at, rr_ptr;
        logic        x_mwr    [int];
        logic [15:0] x_maddr  [int];
        logic [15:0] x_mwdata [int];
        int          x_fch    [int];
        int          x_foff   [int];
        logic [15:0] x_fdata  [int];
        int          x_done   [int];

        logic [NC-1:0] last_done;
        int            fv_cnt;
        logic          env_fin = 1'b0;

        function automatic logic [15:0] mem_read(input logic [15:0] a);
            if (mem_arr.exists(int'(a))) return mem_arr[int'(a)];
            else return 16'(a * 16'h9E37) ^ 16'h5A5A;
        endfunction

        function automatic int pick(input logic [NC-1:0] r);
            int lowest = -1;
            int after  = -1;
            for (int i = 0; i < NC; i++) begin
                if (r[i] && lowest < 0) lowest = i;
                if (r[i] && PM == 1 && i >= rr_ptr && after < 0) after = i;
            end
            return (after >= 0) ? after : lowest;
        endfunction

        task automatic model_and_check();
            logic [NC-1:0] e_done, e_fv;
            logic [15:0]   a, base;
            int            g;
            if (rst) begin
                x_mwr.delete(); x_maddr.delete(); x_mwdata.delete();
                x_fch.delete(); x_foff.delete(); x_fdata.delete(); x_done.delete();
                free_at = cyc + 1;
                rr_ptr  = 0;
                check_eq($sformatf("e%0d rst outputs", e),
                         {ch_stall, ch_done, fill_valid, fill_data, fill_offset, mem_en, mem_wr, mem_addr, mem_wdata}, 64'd0);
                return;
            end
            if (cyc >= free_at && (|ch_req)) begin
                g = pick(ch_req);
                a = ch_addr[g*AW +: AW];
                if (ch_we[g]) begin
                    x_mwr[cyc+1]    = 1'b1;
                    x_maddr[cyc+1]  = a;
                    x_mwdata[cyc+1] = ch_wdata[g*DW +: DW];
                    x_done[cyc+1]   = g;
                    free_at         = cyc + 2;
                end else begin
                    base = a & ~16'(BW - 1);
                    for (int k = 0; k < BW; k++) begin
                        x_mwr[cyc+1+k]       = 1'b0;
                        x_maddr[cyc+1+k]     = 16'(base + 16'(k));
                        x_fch[cyc+1+LAT+k]   = g;
                        x_foff[cyc+1+LAT+k]  = k;
                        x_fdata[cyc+1+LAT+k] = mem_read(16'(base + 16'(k)));
                    end
                    x_done[cyc+LAT+BW] = g;
                    free_at = cyc + LAT + BW + 1;
                end
                rr_ptr = (g + 1) % NC;
            end
            e_done = '0;
            e_fv   = '0;
            if (x_done.exists(cyc)) e_done[x_done[cyc]] = 1'b1;
            if (x_fch.exists(cyc))  e_fv[x_fch[cyc]]    = 1'b1;
            check_eq($sformatf("e%0d ch_done", e), ch_done, e_done);
            check_eq($sformatf("e%0d ch_stall", e), ch_stall, ch_req & ~e_done);
            check_eq($sformatf("e%0d fill_valid", e), fill_valid, e_fv);
            check_eq($sformatf("e%0d mem_en", e), mem_en, x_mwr.exists(cyc));
            if (x_mwr.exists(cyc)) begin
                check_eq($sformatf("e%0d mem_wr", e), mem_wr, x_mwr[cyc]);
                check_eq($sformatf("e%0d mem_addr", e), mem_addr, x_maddr[cyc]);
                if (x_mwr[cyc]) check_eq($sformatf("e%0d mem_wdata", e), mem_wdata, x_mwdata[cyc]);
                x_mwr.delete(cyc); x_maddr.delete(cyc); x_mwdata.delete(cyc);
            end
            if (x_fch.exists(cyc)) begin
                check_eq($sformatf("e%0d fill_data", e), fill_data, x_fdata[cyc]);
                check_eq($sformatf("e%0d fill_offset", e), fill_offset, x_foff[cyc]);
                x_fch.delete(cyc); x_foff.delete(cyc); x_fdata.delete(cyc);
            end
            x_done.delete(cyc);
        endtask

        task automatic step();
            @(posedge clk);
            #1;
            cyc++;
            rst = s_rst;
            for (int i = 0; i < NC; i++) begin
                ch_req[i] = s_req[i];
                ch_we[i]  = s_we[i];
                ch_addr[i*AW +: AW]  = s_addr[i];
                ch_wdata[i*DW +: DW] = s_wdata[i];
            end
            if (due_q.size() > 0 && due_q[0] == cyc) begin
                mem_rvalid = 1'b1;
                mem_rdata  = dat_q[0];
                void'(due_q.pop_front());
                void'(dat_q.pop_front());
            end else begin
                mem_rvalid = 1'b0;
                mem_rdata  = 16'($urandom);
            end
            @(negedge clk);
            model_and_check();
            if (!rst && mem_en) begin
                if (mem_wr) begin
                    mem_arr[int'(mem_addr)] = mem_wdata;
                end else begin
                    due_q.push_back(cyc + LAT);
                    dat_q.push_back(mem_read(mem_addr));
                end
            end
            last_done = ch_done;
            fv_cnt += $countones(fill_valid);
            for (int i = 0; i < NC; i++) if (ch_done[i]) s_req[i] = 1'b0;
        endtask

        task automatic raise(input int ch, input logic we, input logic [15:0] a, input logic [15:0] d);
            s_req[ch] = 1'b1; s_we[ch] = we; s_addr[ch] = a; s_wdata[ch] = d;
        endtask

        task automatic wait_idle(input string tag);
            logic busy = 1'b1;
            for (int t = 0; t < 400 && busy; t++) begin
                step();
                busy = 1'b0;
                for (int i = 0; i < NC; i++) busy |= s_req[i];
            end
            check_eq($sformatf("e%0d %s completes", e, tag), busy, 1'b0);
        endtask

        task automatic random_phase(input int n, input int p);
            for (int t = 0; t < n; t++) begin
                for (int i = 0; i < NC; i++)
                    if (!s_req[i] && $urandom_range(0, 99) < p)
                        raise(i, $urandom_range(0, 3) == 0, 16'($urandom), 16'($urandom));
                step();
            end
        endtask

        initial begin
            cyc = 0; free_at = 0; rr_ptr = 0; fv_cnt = 0; last_done = '0;
            s_rst = 1'b1; rst = 1'b1; ch_req = '0; ch_we = '0; ch_addr = '0; ch_wdata = '0;
            mem_rvalid = 1'b0; mem_rdata = '0;
            for (int i = 0; i < NC; i++) begin
                s_req[i] = 1'b0; s_we[i] = 1'b0; s_addr[i] = '0; s_wdata[i] = '0;
            end
            repeat (3) step();
            s_rst = 1'b0;
            repeat (2) step();
            // single block fill, then a single-word write
            raise(DIR_CH, 1'b0, DIR_ADDR, 16'h0000);
            wait_idle("first fill");
            raise(0, 1'b1, 16'h0040, 16'hBEEF);
            wait_idle("write");
            // every channel asks for a fill in the same cycle
            for (int i = 0; i < NC; i++) raise(i, 1'b0, 16'(16'h0100 + 16'(i * 16'h0033)), 16'h0000);
            wait_idle("simultaneous fills");
            // reset after the third fill word, strays drain, then a clean fill
            raise(0, 1'b0, 16'h0120, 16'h0000);
            fv_cnt = 0;
            for (int t = 0; t < 100 && fv_cnt < 3; t++) step();
            check_eq($sformatf("e%0d words before reset", e), fv_cnt, 3);
            s_rst = 1'b1;
            for (int i = 0; i < NC; i++) s_req[i] = 1'b0;
            step();
            s_rst = 1'b0;
            repeat (LAT + BW + 4) step();
            raise(1, 1'b0, 16'h0231, 16'h0000);
            wait_idle("fill after reset");
            random_phase(1200, RAND_P);
            random_phase(1500, 25);
            wait_idle("random tail");
            env_fin = 1'b1;
        end
    end

    initial begin
        for (int t = 0; t < 20000 && !(g_env[0].env_fin && g_env[1].env_fin); t++) @(posedge clk);
        check_eq("both environments finished", {g_env[0].env_fin, g_env[1].env_fin}, 2'b11);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
